// File: rtl/pulse_stretcher_if.sv
// pulse_stretcher_if
//   Trigger/status bundle between a pulse stretcher and its user.
//   master : drives TriggerPulse and ClearOverflow, observes the status outputs.
//   slave  : the stretcher itself.
//   Signals:
//     TriggerPulse  - single-cycle event, one trigger per clock it is high
//     ClearOverflow - synchronous clear of the sticky Overflow flag
//     Stretched     - stretched output level
//     Done          - one-cycle marker at the end of each stretched pulse
//     Busy          - stretcher is in HIGH or LOW
//     Pending       - number of queued triggers
//     Overflow      - sticky: a trigger was dropped because the queue was full
interface pulse_stretcher_if #(
  parameter int QUEUE_MAX = 3
) ();
  localparam int PENDING_W = $clog2(QUEUE_MAX + 1);

  logic                 TriggerPulse;
  logic                 ClearOverflow;
  logic                 Stretched;
  logic                 Done;
  logic                 Busy;
  logic [PENDING_W-1:0] Pending;
  logic                 Overflow;

  modport master (
    output TriggerPulse, ClearOverflow,
    input  Stretched, Done, Busy, Pending, Overflow
  );

  modport slave (
    input  TriggerPulse, ClearOverflow,
    output Stretched, Done, Busy, Pending, Overflow
  );
endinterface

// File: rtl/pulse_stretcher.sv
// pulse_stretcher
//   Turns single-cycle trigger pulses into fixed-length high levels separated
//   by a guaranteed low gap. Triggers arriving during a pulse are queued (up to
//   QUEUE_MAX) or, with RETRIGGER=1, restart the high count of the current pulse.
//   Ports:
//     CLOCK - system clock, rising edge
//     Reset - synchronous, active-high reset
//     port  - pulse_stretcher_if slave modport (trigger in, status out)
//   Parameters:
//     HIGH_CYCLES - stretched pulse length in clocks (>=1)
//     LOW_CYCLES  - minimum low gap after each pulse in clocks (>=1)
//     QUEUE_MAX   - maximum number of queued triggers (>=1)
//     RETRIGGER   - 1: trigger during HIGH restarts the high count; 0: queued
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2,
  parameter int QUEUE_MAX   = 3,
  parameter int RETRIGGER   = 0
) (
  input  logic              CLOCK,
  input  logic              Reset,
  pulse_stretcher_if.slave  port
);
  localparam int MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int PENDING_W  = $clog2(QUEUE_MAX + 1);

  localparam logic [CNT_W-1:0]     HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]     LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [PENDING_W-1:0] PEND_MAX  = PENDING_W'(QUEUE_MAX);
  localparam bit                   RETRIG_EN = (RETRIGGER != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } stateT;

  stateT                state;
  logic [CNT_W-1:0]     count;     // shared down-counter for HIGH and LOW
  logic                 stretched;
  logic                 done;
  logic                 busy;
  logic [PENDING_W-1:0] pending;
  logic                 overflow;

  logic queueFull;
  assign queueFull = (pending == PEND_MAX);

  // NOTE: every register here is written with <= so all of them update from
  // the same pre-edge values; mixing in = would make later statements see
  // half-updated state and change behaviour with statement order.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state     <= IDLE;
      count     <= '0;
      stretched <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      pending   <= '0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      // Clear first; a set later in this block overrides it on the same edge.
      if (port.ClearOverflow) overflow <= 1'b0;

      case (state)
        IDLE: begin
          if (port.TriggerPulse) begin
            state     <= HIGH;
            count     <= HIGH_LOAD;
            stretched <= 1'b1;
            busy      <= 1'b1;
          end
        end

        HIGH: begin
          if (port.TriggerPulse && RETRIG_EN) begin
            // Restart also covers the last HIGH edge: no Done, stay in HIGH.
            count <= HIGH_LOAD;
          end else begin
            if (port.TriggerPulse) begin
              if (queueFull) overflow <= 1'b1;
              else           pending  <= pending + PENDING_W'(1);
            end
            if (count == '0) begin
              state     <= LOW;
              count     <= LOW_LOAD;
              stretched <= 1'b0;
              done      <= 1'b1;
            end else begin
              count <= count - CNT_W'(1);
            end
          end
        end

        LOW: begin
          if (count == '0) begin
            if (pending != '0 || port.TriggerPulse) begin
              state     <= HIGH;
              count     <= HIGH_LOAD;
              stretched <= 1'b1;
              // A trigger on this edge replaces the dequeued entry (or starts
              // the pulse directly when the queue is empty), so Pending only
              // drops when there is no trigger.
              if (!port.TriggerPulse) pending <= pending - PENDING_W'(1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            count <= count - CNT_W'(1);
            if (port.TriggerPulse) begin
              if (queueFull) overflow <= 1'b1;
              else           pending  <= pending + PENDING_W'(1);
            end
          end
        end

        default: begin
          state     <= IDLE;
          count     <= '0;
          stretched <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign port.Stretched = stretched;
  assign port.Done      = done;
  assign port.Busy      = busy;
  assign port.Pending   = pending;
  assign port.Overflow  = overflow;
endmodule
